// File: rtl/breath_led_pkg.sv
// Shared definitions for breath_led: FSM state encoding and default parameters.
// Hold states are only defined when BREATH_LED_HOLD_EN is set.
package breath_led_pkg;

   localparam int unsigned PWM_BITS_DEF   = 8;
   localparam int unsigned STEP_DIV_DEF   = 64;
   localparam int unsigned HOLD_STEPS_DEF = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_RISE    = 3'd1;
   localparam state_t ST_FALL    = 3'd2;
`ifdef BREATH_LED_HOLD_EN
   localparam state_t ST_HOLD_HI = 3'd3;
   localparam state_t ST_HOLD_LO = 3'd4;
`endif

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/breath_pwm.sv
// PWM engine for breath_led: free-running period counter, period-end flag
// and registered duty compare driving the LED.
module breath_pwm #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_clr,
   input  logic                i_run,
   input  logic                i_en,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_period_end,
   output logic                o_led
);

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] r_cnt;
   logic                r_led;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_led <= 1'b0;
      end else begin
         if (i_clr) begin
            r_cnt <= '0;
         end else if (i_run) begin
            r_cnt <= r_cnt + PWM_BITS'(1);
         end
         r_led <= i_en && (r_cnt < i_duty);
      end
   end

   assign o_period_end = i_run && (r_cnt == CNT_MAX);
   assign o_led        = r_led;

endmodule

// File: rtl/breath_led.sv
// Breathing LED: duty ramps up and down one step every STEP_DIV PWM periods.
// Define BREATH_LED_HOLD_EN to add HOLD_HI/HOLD_LO dwell states of HOLD_STEPS steps.
module breath_led
   import breath_led_pkg::*;
#(
   parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
   parameter int unsigned STEP_DIV   = STEP_DIV_DEF,
   parameter int unsigned HOLD_STEPS = HOLD_STEPS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_breath,
   output logic led
);

   localparam int unsigned         SW        = cnt_width(STEP_DIV);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] DUTY_PMAX = DUTY_MAX - DUTY_ONE;

   if (STEP_DIV < 1 || HOLD_STEPS < 1) begin : g_param_check
      $error("breath_led: STEP_DIV and HOLD_STEPS must be >= 1");
   end

   state_t              r_state;
   logic [PWM_BITS-1:0] r_duty;
   logic [SW-1:0]       r_step_cnt;
   logic                w_run;
   logic                w_period_end;
   logic                w_tick;
   logic                w_hold_done;

   // The PWM counter stays parked at 0 in IDLE so RISE starts from a clean period.
   assign w_run  = en_breath && (r_state != ST_IDLE);
   assign w_tick = w_period_end && (r_step_cnt == SW'(STEP_DIV - 1));

   breath_pwm #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (!en_breath),
      .i_run        (w_run),
      .i_en         (en_breath),
      .i_duty       (r_duty),
      .o_period_end (w_period_end),
      .o_led        (led)
   );

`ifdef BREATH_LED_HOLD_EN
   localparam int unsigned HW = cnt_width(HOLD_STEPS);

   logic [HW-1:0] r_hold_cnt;

   assign w_hold_done = (r_hold_cnt == HW'(HOLD_STEPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
      end else if (!en_breath) begin
         r_hold_cnt <= '0;
      end else if (w_tick && (r_state == ST_HOLD_HI || r_state == ST_HOLD_LO)) begin
         r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + HW'(1);
      end
   end
`else
   assign w_hold_done = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_duty     <= '0;
         r_step_cnt <= '0;
      end else if (!en_breath) begin
         r_state    <= ST_IDLE;
         r_duty     <= '0;
         r_step_cnt <= '0;
      end else begin
         if (w_period_end) begin
            r_step_cnt <= w_tick ? '0 : r_step_cnt + SW'(1);
         end
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_RISE;
            end
            ST_RISE: begin
               if (w_tick) begin
                  r_duty <= r_duty + DUTY_ONE;
                  if (r_duty == DUTY_PMAX) begin
`ifdef BREATH_LED_HOLD_EN
                     r_state <= ST_HOLD_HI;
`else
                     r_state <= ST_FALL;
`endif
                  end
               end
            end
            ST_FALL: begin
               if (w_tick) begin
                  r_duty <= r_duty - DUTY_ONE;
                  if (r_duty == DUTY_ONE) begin
`ifdef BREATH_LED_HOLD_EN
                     r_state <= ST_HOLD_LO;
`else
                     r_state <= ST_RISE;
`endif
                  end
               end
            end
`ifdef BREATH_LED_HOLD_EN
            ST_HOLD_HI: begin
               if (w_tick && w_hold_done) begin
                  r_state <= ST_FALL;
               end
            end
            ST_HOLD_LO: begin
               if (w_tick && w_hold_done) begin
                  r_state <= ST_RISE;
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
               r_duty  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_breath_led.sv
// Directed bench for breath_led at PWM_BITS=3, STEP_DIV=2, HOLD_STEPS=2.
// Expected duty/led trajectories are derived by hand from the ramp timing.
module tb_breath_led;
   import breath_led_pkg::*;

   localparam int PB = 3;
   localparam int SD = 2;
   localparam int HS = 2;
`ifdef BREATH_LED_HOLD_EN
   localparam int PERIOD = 288;
`else
   localparam int PERIOD = 224;
`endif

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic en_breath = 1'b0;
   logic led;

   int n_vec = 0;
   int n_err = 0;

   breath_led #(
      .PWM_BITS   (PB),
      .STEP_DIV   (SD),
      .HOLD_STEPS (HS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_breath (en_breath),
      .led       (led)
   );

   always #5 clk = ~clk;

   // Duty after the t-th enabled edge (edge 0 = IDLE->RISE); each level lasts 16 clk.
   function automatic int exp_duty(input int t);
      int i;
`ifdef BREATH_LED_HOLD_EN
      i = (t / 16) % 18;
      if (i <= 7) return i;
      else if (i <= 9) return 7;
      else if (i <= 16) return 16 - i;
      else return 0;
`else
      i = (t / 16) % 14;
      return (i <= 7) ? i : 14 - i;
`endif
   endfunction

   // led after edge t reflects counter (t-1)%8 against duty after edge t-1.
   function automatic logic exp_led(input int t);
      if (t == 0) return 1'b0;
      return (((t - 1) % 8) < exp_duty(t - 1)) ? 1'b1 : 1'b0;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      en_breath = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (led !== 1'b0 || dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset c=%0d: led=%b state=%0d, want led=0 state=%0d",
                     i, led, dut.r_state, ST_IDLE);
         end
      end
      en_breath = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_off();
      en_breath = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         n_vec++;
         if (led !== 1'b0) begin
            n_err++;
            $display("FAIL off c=%0d: led=%b want 0", i, led);
         end
      end
      n_vec++;
      if (dut.r_duty !== 3'd0 || dut.r_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL off_state: duty=%0d state=%0d, want 0/%0d", dut.r_duty, dut.r_state, ST_IDLE);
      end
   endtask

   task automatic test_first_light();
      logic want;
      en_breath = 1'b1;
      for (int t = 0; t <= 32; t++) begin
         @(negedge clk);
         want = (t >= 17 && ((t - 1) % 8) == 0) ? 1'b1 : 1'b0;
         n_vec++;
         if (led !== want) begin
            n_err++;
            $display("FAIL first_light t=%0d: led=%b want %b", t, led, want);
         end
      end
      en_breath = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_breath();
      en_breath = 1'b1;
      for (int t = 0; t < 2 * PERIOD + 20; t++) begin
         @(negedge clk);
         n_vec++;
         if (led !== exp_led(t) || dut.r_duty !== 3'(exp_duty(t))) begin
            n_err++;
            $display("FAIL breath t=%0d: led=%b duty=%0d, want led=%b duty=%0d",
                     t, led, dut.r_duty, exp_led(t), exp_duty(t));
         end
      end
      en_breath = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_drop_restart();
      en_breath = 1'b1;
      for (int t = 0; t <= 84; t++) begin
         @(negedge clk);
      end
      n_vec++;
      if (dut.r_duty !== 3'd5) begin
         n_err++;
         $display("FAIL drop_pre: duty=%0d want 5", dut.r_duty);
      end
      // Without the drop the next edge would light the LED (counter 4 < duty 5).
      en_breath = 1'b0;
      @(negedge clk);
      n_vec++;
      if (led !== 1'b0 || dut.r_duty !== 3'd0 || dut.r_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL drop: led=%b duty=%0d state=%0d, want 0/0/%0d",
                  led, dut.r_duty, dut.r_state, ST_IDLE);
      end
      repeat (3) @(negedge clk);
      en_breath = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         @(negedge clk);
         n_vec++;
         if (led !== exp_led(t) || dut.r_duty !== 3'(exp_duty(t))) begin
            n_err++;
            $display("FAIL restart t=%0d: led=%b duty=%0d, want led=%b duty=%0d",
                     t, led, dut.r_duty, exp_led(t), exp_duty(t));
         end
      end
      en_breath = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      en_breath = 1'b1;
      for (int t = 0; t <= 81; t++) begin
         @(negedge clk);
      end
      n_vec++;
      if (led !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre: led=%b want 1", led);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (led !== 1'b0 || dut.r_duty !== 3'd0 || dut.r_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL async_reset: led=%b duty=%0d state=%0d, want 0/0/%0d",
                  led, dut.r_duty, dut.r_state, ST_IDLE);
      end
      repeat (2) @(negedge clk);
      n_vec++;
      if (led !== 1'b0 || dut.r_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL async_hold: led=%b state=%0d, want 0/%0d", led, dut.r_state, ST_IDLE);
      end
      rst_n = 1'b1;
      for (int t = 0; t <= 24; t++) begin
         @(negedge clk);
         n_vec++;
         if (led !== exp_led(t) || dut.r_duty !== 3'(exp_duty(t))) begin
            n_err++;
            $display("FAIL post_reset t=%0d: led=%b duty=%0d, want led=%b duty=%0d",
                     t, led, dut.r_duty, exp_led(t), exp_duty(t));
         end
      end
      en_breath = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_off();
      test_first_light();
      test_breath();
      test_drop_restart();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/breath_led.md
BREATH_LED -- requirements
Module: breath_led

Interface
REQ-001 Parameter PWM_BITS, default 8; width of the PWM counter and duty register (PWM period = 2^PWM_BITS clk).
REQ-002 Parameter STEP_DIV, default 64; PWM periods per duty step (>=1).
REQ-003 Parameter HOLD_STEPS, default 32; hold length in steps, used only with BREATH_LED_HOLD_EN.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en_breath  input  1  synchronous enable; 1 = breathe, 0 = LED off and restart.
REQ-007 led  output  1  registered PWM drive, active-high.

Function
REQ-008 The PWM counter SHALL increment each clk while enabled and wrap from 2^PWM_BITS-1 to 0.
REQ-009 A period end SHALL be the counter at maximum; a step counter SHALL count period ends and produce a step tick at count STEP_DIV-1, then return to 0.
REQ-010 The FSM SHALL have states IDLE, RISE, FALL (plus HOLD_HI and HOLD_LO with the macro).
REQ-011 IDLE with en_breath=1 SHALL go to RISE next cycle, with duty=0 and all counters 0.
REQ-012 On a RISE tick, duty SHALL increment; when the new duty equals 2^PWM_BITS-1, the FSM SHALL go to FALL (or HOLD_HI).
REQ-013 On a FALL tick, duty SHALL decrement; when the new duty equals 0, the FSM SHALL go to RISE (or HOLD_LO).
REQ-014 led SHALL be registered as en_breath AND (pwm_cnt < duty), giving one-cycle latency.
REQ-015 Duty 0 SHALL keep led at 0; duty max SHALL drive led high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-016 en_breath=0 in any state SHALL synchronously clear duty, both counters and led, and force IDLE; led SHALL be 0 from the next edge.
REQ-017 Re-enable mid-ramp SHALL restart from duty 0; partial progress SHALL NOT be retained.
REQ-018 Without hold, the full breath cycle SHALL be 2*(2^PWM_BITS-1)*STEP_DIV*2^PWM_BITS clk.

Reset
REQ-019 rst_n=0 SHALL asynchronously force led=0, duty=0, both counters=0 and state IDLE.
REQ-020 Reset release SHALL take effect on the next clk edge; the first rising edge with rst_n=1 behaves as REQ-011 or REQ-016.

Configuration
REQ-021 Macro BREATH_LED_HOLD_EN defined: HOLD_HI and HOLD_LO each SHALL last HOLD_STEPS step ticks with duty frozen at max or 0, then go to FALL or RISE respectively.
REQ-022 Macro BREATH_LED_HOLD_EN undefined: the hold states and hold counter SHALL NOT exist, and transitions SHALL be direct per REQ-012/013.

Structure
REQ-023 Package breath_led_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-024 One sub-module, breath_pwm (PWM counter, period-end flag, compare to led), SHALL be instantiated; step counter, duty and FSM SHALL stay in breath_led.

Verification (PWM_BITS=3, STEP_DIV=2, HOLD_STEPS=2)
REQ-025 rst_n=0 with en_breath=1 -> led=0 and state IDLE throughout the reset.
REQ-026 en_breath held 0 for 500 cycles -> led constantly 0.
REQ-027 en_breath rises -> led 0 for the first 17 cycles, then high 1 cycle in each 8 while duty=1.
REQ-028 en_breath held 1 without the macro -> duty rises 0..7 then falls 7..0; the breath period is 224 cycles and repeats exactly.
REQ-029 en_breath drops at duty=5 -> led=0 next cycle; re-enable -> ramp restarts at duty 0.
REQ-030 Macro defined -> duty holds 7 for 32 cycles and 0 for 32 cycles; the breath period is 288 cycles.
